// File: rtl/dm_unit_pkg.sv
// Shared encodings for the data-memory unit: dm_ctrl access codes, MMIO register offsets
// and small decode helpers.
package dm_unit_pkg;

  typedef enum logic [2:0] {
    dm_word              = 3'b000,
    dm_halfword          = 3'b001,
    dm_halfword_unsigned = 3'b010,
    dm_byte              = 3'b011,
    dm_byte_unsigned     = 3'b100
  } dm_ctrl_e;

  typedef enum logic [1:0] {
    sz_word,
    sz_half,
    sz_byte
  } dm_size_e;

  localparam logic [3:0] MMIO_LED = 4'h0;
  localparam logic [3:0] MMIO_SW  = 4'h4;
  localparam logic [3:0] MMIO_CYC = 4'h8;
  localparam logic [3:0] MMIO_ERR = 4'hC;

  // Reserved dm_ctrl codes fall back to a full-word access.
  function automatic dm_size_e ctrl_size(input logic [2:0] ctrl);
    case (ctrl)
      dm_halfword, dm_halfword_unsigned: ctrl_size = sz_half;
      dm_byte, dm_byte_unsigned:         ctrl_size = sz_byte;
      default:                           ctrl_size = sz_word;
    endcase
  endfunction

  function automatic logic ctrl_signed(input logic [2:0] ctrl);
    ctrl_signed = (ctrl == dm_halfword) || (ctrl == dm_byte);
  endfunction

endpackage

// File: rtl/dm_sync2.sv
// Two-flop synchroniser for asynchronous level inputs; clears to zero on reset.
module dm_sync2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dm_unit.sv
// Data-memory stage: word RAM with byte/half lane steering and load extension,
// a 16-byte MMIO window (LED, switches, cycle counter, error) and sticky misalignment capture.
module dm_unit
  import dm_unit_pkg::*;
#(
  parameter int          DEPTH_W   = 1024,
  parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
  parameter int          SW_W      = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            mem_w,
  input  logic [31:0]     addr,
  input  logic [31:0]     wdata,
  input  logic [2:0]      dm_ctrl,
  output logic [31:0]     rdata,
  input  logic [SW_W-1:0] sw_in,
  output logic [SW_W-1:0] led_out,
  output logic            err_o,
  output logic [31:0]     err_addr
);

  localparam int AW = $clog2(DEPTH_W);

  logic [31:0]     mem [DEPTH_W];
  logic [AW-1:0]   idx;
  dm_size_e        size;
  logic            sgn;
  logic            is_mmio;
  logic            misalign;
  logic            fault;
  logic [31:0]     ram_word;
  logic [31:0]     ram_rd;
  logic [15:0]     half;
  logic [7:0]      byte_v;
  logic [3:0]      be;
  logic [31:0]     wd;
  logic            ram_we;
  logic            mmio_we;
  logic [SW_W-1:0] sw_sync;
  logic [31:0]     cyc_cnt;

  assign idx      = addr[AW+1:2];
  assign size     = ctrl_size(dm_ctrl);
  assign sgn      = ctrl_signed(dm_ctrl);
  assign is_mmio  = (addr[31:4] == MMIO_BASE[31:4]);
  assign misalign = ((size == sz_word) && (addr[1:0] != 2'b00)) ||
                    ((size == sz_half) && addr[0]);
  assign fault    = misalign || (is_mmio && (size != sz_word));
  assign ram_word = mem[idx];
  assign ram_we   = mem_w && !fault && !is_mmio;
  assign mmio_we  = mem_w && !fault && is_mmio;

  dm_sync2 #(.W(SW_W)) u_sw_sync (
    .clk (clk),
    .rst (rst),
    .d   (sw_in),
    .q   (sw_sync)
  );

  always_comb begin
    half   = addr[1] ? ram_word[31:16] : ram_word[15:0];
    byte_v = ram_word[7:0];
    case (addr[1:0])
      2'd1:    byte_v = ram_word[15:8];
      2'd2:    byte_v = ram_word[23:16];
      2'd3:    byte_v = ram_word[31:24];
      default: byte_v = ram_word[7:0];
    endcase
    case (size)
      sz_half: ram_rd = sgn ? {{16{half[15]}}, half} : {16'h0, half};
      sz_byte: ram_rd = sgn ? {{24{byte_v[7]}}, byte_v} : {24'h0, byte_v};
      default: ram_rd = ram_word;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (!fault) begin
      if (is_mmio) begin
        case (addr[3:0])
          MMIO_LED: rdata = 32'(led_out);
          MMIO_SW:  rdata = 32'(sw_sync);
          MMIO_CYC: rdata = cyc_cnt;
          MMIO_ERR: rdata = {31'h0, err_o};
          default:  rdata = '0;
        endcase
      end else begin
        rdata = ram_rd;
      end
    end
  end

  // Narrow stores replicate the value across lanes; the byte enables pick the target lane.
  always_comb begin
    be = 4'b1111;
    wd = wdata;
    case (size)
      sz_half: begin
        be = addr[1] ? 4'b1100 : 4'b0011;
        wd = {2{wdata[15:0]}};
      end
      sz_byte: begin
        be = 4'b0001 << addr[1:0];
        wd = {4{wdata[7:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = wdata;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wd[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_out  <= '0;
      cyc_cnt  <= '0;
      err_o    <= 1'b0;
      err_addr <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      if (mmio_we && (addr[3:0] == MMIO_LED)) led_out <= wdata[SW_W-1:0];
      if (mmio_we && (addr[3:0] == MMIO_ERR)) begin
        err_o    <= 1'b0;
        err_addr <= '0;
      end else if (fault && !err_o) begin
        err_o    <= 1'b1;
        err_addr <= addr;
      end
    end
  end

endmodule

// File: tb/tb_dm_unit.sv
// Directed bench for dm_unit: vector table for RAM lane steering, plus hand sequences for
// counter, faults, switch synchroniser, LED and async reset.
module tb_dm_unit;

  localparam logic [31:0] MB = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [2:0]  dm_ctrl = 3'b000;
  logic [31:0] rdata;
  logic [15:0] sw_in = '0;
  logic [15:0] led_out;
  logic        err_o;
  logic [31:0] err_addr;

  int checks = 0;
  int failures = 0;

  dm_unit dut (
    .clk      (clk),
    .rst      (rst),
    .mem_w    (mem_w),
    .addr     (addr),
    .wdata    (wdata),
    .dm_ctrl  (dm_ctrl),
    .rdata    (rdata),
    .sw_in    (sw_in),
    .led_out  (led_out),
    .err_o    (err_o),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
    logic        chk;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic put(input logic we, input logic [31:0] a, input logic [31:0] d, input logic [2:0] c);
    mem_w = we; addr = a; wdata = d; dm_ctrl = c;
  endtask

  task automatic idle();
    put(1'b0, 32'h0, 32'h0, 3'b000);
  endtask

  initial begin
    vecs.push_back('{1'b1, 32'h10,   32'h1234_5678, 3'b000, 1'b0, 32'h0});
    vecs.push_back('{1'b0, 32'h13,   32'h0,         3'b011, 1'b1, 32'h0000_0012});
    vecs.push_back('{1'b0, 32'h12,   32'h0,         3'b001, 1'b1, 32'h0000_1234});
    vecs.push_back('{1'b0, 32'h10,   32'h0,         3'b000, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b0, 32'h11,   32'h0,         3'b100, 1'b1, 32'h0000_0056});
    vecs.push_back('{1'b0, 32'h1010, 32'h0,         3'b000, 1'b1, 32'h1234_5678});
    vecs.push_back('{1'b1, 32'h20,   32'h0,         3'b000, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h21,   32'h80,        3'b011, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   32'h0,         3'b000, 1'b1, 32'h0000_8000});
    vecs.push_back('{1'b0, 32'h21,   32'h0,         3'b011, 1'b1, 32'hFFFF_FF80});
    vecs.push_back('{1'b0, 32'h21,   32'h0,         3'b100, 1'b1, 32'h0000_0080});
    vecs.push_back('{1'b1, 32'h22,   32'hBEEF,      3'b001, 1'b1, 32'h0});
    vecs.push_back('{1'b0, 32'h20,   32'h0,         3'b000, 1'b1, 32'hBEEF_8000});
    vecs.push_back('{1'b0, 32'h22,   32'h0,         3'b001, 1'b1, 32'hFFFF_BEEF});
    vecs.push_back('{1'b0, 32'h22,   32'h0,         3'b010, 1'b1, 32'h0000_BEEF});
    vecs.push_back('{1'b0, 32'h20,   32'h0,         3'b001, 1'b1, 32'hFFFF_8000});
    vecs.push_back('{1'b0, 32'h20,   32'h0,         3'b111, 1'b1, 32'hBEEF_8000});
    vecs.push_back('{1'b1, 32'h30,   32'h1111_1111, 3'b000, 1'b0, 32'h0});
    vecs.push_back('{1'b1, 32'h30,   32'h2222_2222, 3'b000, 1'b1, 32'h1111_1111});
    vecs.push_back('{1'b0, 32'h30,   32'h0,         3'b000, 1'b1, 32'h2222_2222});
    vecs.push_back('{1'b1, 32'h33,   32'hFF,        3'b011, 1'b1, 32'h0000_0022});
    vecs.push_back('{1'b0, 32'h30,   32'h0,         3'b000, 1'b1, 32'hFF22_2222});

    // Reset values, then cycle counter after 100 edges out of reset.
    idle();
    #12;
    check("rst_led", 32'(led_out), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    check("rst_err_addr", err_addr, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    put(1'b0, MB + 32'h8, 32'h0, 3'b000);
    #1 check("cyc_100", rdata, 32'd100);
    @(negedge clk);
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    #1 check("cyc_forced", rdata, 32'hFFFF_FFFF);
    release dut.cyc_cnt;
    @(negedge clk);
    #1 check("cyc_wrap", rdata, 32'h0);

    // RAM lane steering table.
    foreach (vecs[i]) begin
      @(negedge clk);
      put(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].c);
      #1;
      if (vecs[i].chk) check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp);
      check($sformatf("vec%0d_err", i), 32'(err_o), 32'h0);
    end

    // Misaligned store, sticky capture, clear via ERR register.
    @(negedge clk); put(1'b1, 32'h04, 32'hCAFE_F00D, 3'b000);
    @(negedge clk); put(1'b1, 32'h06, 32'hDEAD_BEEF, 3'b000);
    #1 check("mis_rdata", rdata, 32'h0);
    @(negedge clk); put(1'b0, 32'h11, 32'h0, 3'b001);
    #1 check("mis_err", 32'(err_o), 32'h1);
    check("mis_err_addr", err_addr, 32'h06);
    check("mis_lh_rdata", rdata, 32'h0);
    @(negedge clk); put(1'b0, 32'h04, 32'h0, 3'b000);
    #1 check("mis_word1_kept", rdata, 32'hCAFE_F00D);
    check("mis_err_addr_first", err_addr, 32'h06);
    @(negedge clk); put(1'b0, MB + 32'hC, 32'h0, 3'b000);
    #1 check("err_reg_read", rdata, 32'h1);
    @(negedge clk); put(1'b1, MB + 32'hC, 32'h1234, 3'b000);
    @(negedge clk); idle();
    #1 check("clr_err", 32'(err_o), 32'h0);
    check("clr_err_addr", err_addr, 32'h0);

    // Switch synchroniser latency, LED store, illegal byte MMIO store.
    @(negedge clk);
    put(1'b0, MB + 32'h4, 32'h0, 3'b000);
    sw_in = 16'hA5A5;
    #1 check("sw_cyc1", rdata, 32'h0);
    @(negedge clk); #1 check("sw_cyc2", rdata, 32'h0);
    @(negedge clk); #1 check("sw_cyc3", rdata, 32'h0000_A5A5);
    @(negedge clk); put(1'b1, MB, 32'h1_00FF, 3'b000);
    @(negedge clk); put(1'b0, MB, 32'h0, 3'b000);
    #1 check("led_out", 32'(led_out), 32'h00FF);
    check("led_read", rdata, 32'h0000_00FF);
    @(negedge clk); put(1'b1, MB, 32'h33, 3'b011);
    #1 check("mmio_b_rdata", rdata, 32'h0);
    @(negedge clk); idle();
    #1 check("mmio_b_led", 32'(led_out), 32'h00FF);
    check("mmio_b_err", 32'(err_o), 32'h1);
    check("mmio_b_err_addr", err_addr, MB);

    // Asynchronous reset mid-cycle; RAM retains contents.
    @(negedge clk);
    put(1'b0, MB + 32'h4, 32'h0, 3'b000);
    #2 rst = 1'b0;
    #1;
    check("arst_led", 32'(led_out), 32'h0);
    check("arst_err", 32'(err_o), 32'h0);
    check("arst_err_addr", err_addr, 32'h0);
    check("arst_sw", rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    put(1'b0, 32'h10, 32'h0, 3'b000);
    #1 check("arst_ram_kept", rdata, 32'h1234_5678);
    put(1'b0, MB + 32'h8, 32'h0, 3'b000);
    #1 check("arst_cyc", rdata, 32'h0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
